// File: rtl/cpu_reg_file_pc_if.sv
// Signal bundle between the decode/writeback stages and the register file.
// CLK and CLR stay plain ports on the register file itself.
interface cpu_reg_file_pc_if #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
);
    // No valid/ready handshake: every request (REG_WE, MARK_EN, PC_EN, PC_INC)
    // is a single-cycle strobe taken on the rising edge when TICK is high.
    logic              TICK;
    logic              REG_WE;
    logic [SEL_W-1:0]  REG_SEL;
    logic [DATA_W-1:0] REG_BUS;
    logic [SEL_W-1:0]  REG_1_SEL;
    logic [SEL_W-1:0]  REG_2_SEL;
    logic [DATA_W-1:0] REG_1_OUT;
    logic [DATA_W-1:0] REG_2_OUT;
    logic              REG_1_BUSY;
    logic              REG_2_BUSY;
    logic              MARK_EN;
    logic [SEL_W-1:0]  MARK_SEL;
    logic              PC_EN;
    logic              PC_INC;
    logic [DATA_W-1:0] PC_BUS;
    logic [DATA_W-1:0] PC_OUT;

    modport master (
        output TICK, REG_WE, REG_SEL, REG_BUS, REG_1_SEL, REG_2_SEL,
               MARK_EN, MARK_SEL, PC_EN, PC_INC, PC_BUS,
        input  REG_1_OUT, REG_2_OUT, REG_1_BUSY, REG_2_BUSY, PC_OUT
    );

    modport slave (
        input  TICK, REG_WE, REG_SEL, REG_BUS, REG_1_SEL, REG_2_SEL,
               MARK_EN, MARK_SEL, PC_EN, PC_INC, PC_BUS,
        output REG_1_OUT, REG_2_OUT, REG_1_BUSY, REG_2_BUSY, PC_OUT
    );
endinterface

// File: rtl/cpu_reg_file_pc.sv
// Register file with 2^SEL_W entries (top entry is the PC), two async read ports
// and a pending-write scoreboard. Define RF_BYPASS_EN for write-through forwarding.
module cpu_reg_file_pc #(
    parameter int          DATA_W   = 32,
    parameter int          SEL_W    = 4,
    parameter int unsigned PC_STEP  = 4,
    parameter int unsigned PC_RESET = 0
) (
    input logic              CLK,
    input logic              CLR,
    cpu_reg_file_pc_if.slave bus
);
    localparam int NUM = 1 << SEL_W;
    localparam int TOP = NUM - 1;

    logic [DATA_W-1:0]     gpr [TOP];
    logic [DATA_W-1:0]     pc;
    logic [TOP-1:0]        pend;
    logic [NUM-1:0]        wr_dec;
    logic [NUM-1:0]        mark_dec;
    logic [NUM*DATA_W-1:0] flat;
    logic [NUM-1:0]        pend_flat;
    logic [DATA_W-1:0]     rd1_stored;
    logic [DATA_W-1:0]     rd2_stored;

    // One-hot decoders; the top bit is forced low so the PC is never a GPR target.
    always_comb begin
        wr_dec   = '0;
        mark_dec = '0;
        if (bus.REG_WE)  wr_dec[bus.REG_SEL]    = 1'b1;
        if (bus.MARK_EN) mark_dec[bus.MARK_SEL] = 1'b1;
        wr_dec[TOP]   = 1'b0;
        mark_dec[TOP] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            for (int i = 0; i < TOP; i++) gpr[i] <= '0;
            pc   <= DATA_W'(PC_RESET);
            pend <= '0;
        end else if (bus.TICK) begin
            for (int i = 0; i < TOP; i++) begin
                if (wr_dec[i]) gpr[i] <= bus.REG_BUS;
            end
            // A mark on the same index as a write wins over the write's clear.
            pend <= mark_dec[TOP-1:0] | (pend & ~wr_dec[TOP-1:0]);
            if (bus.PC_EN)       pc <= bus.PC_BUS;
            else if (bus.PC_INC) pc <= pc + DATA_W'(PC_STEP);
        end
    end

    always_comb begin
        flat = '0;
        for (int i = 0; i < TOP; i++) flat[i*DATA_W +: DATA_W] = gpr[i];
        flat[TOP*DATA_W +: DATA_W] = pc;
        pend_flat = {1'b0, pend};
    end

    assign rd1_stored = flat[int'(bus.REG_1_SEL)*DATA_W +: DATA_W];
    assign rd2_stored = flat[int'(bus.REG_2_SEL)*DATA_W +: DATA_W];

    always_comb begin
        bus.REG_1_OUT  = rd1_stored;
        bus.REG_2_OUT  = rd2_stored;
        bus.REG_1_BUSY = pend_flat[bus.REG_1_SEL];
        bus.REG_2_BUSY = pend_flat[bus.REG_2_SEL];
`ifdef RF_BYPASS_EN
        // wr_dec already excludes the PC index, so it doubles as the forward match.
        if (bus.TICK && wr_dec[bus.REG_1_SEL]) begin
            bus.REG_1_OUT  = bus.REG_BUS;
            bus.REG_1_BUSY = mark_dec[bus.REG_1_SEL];
        end
        if (bus.TICK && wr_dec[bus.REG_2_SEL]) begin
            bus.REG_2_OUT  = bus.REG_BUS;
            bus.REG_2_BUSY = mark_dec[bus.REG_2_SEL];
        end
`endif
    end

    assign bus.PC_OUT = pc;
endmodule

// File: tb/tb_cpu_reg_file_pc.sv
// Self-checking bench: directed literal checks plus a randomized run compared
// every cycle against an array-based model of the register file.
module tb_cpu_reg_file_pc;
    localparam int DW = 32;
    localparam int SW = 4;

    logic CLK;
    logic CLR;
    int   n_cmp;
    int   n_bad;
    logic chk_en;
    logic [DW-1:0] exp_q[$];

    logic [DW-1:0] m_reg  [16];
    logic          m_pend [16];
    logic [DW-1:0] m_pc;

    cpu_reg_file_pc_if #(.DATA_W(DW), .SEL_W(SW)) rf_if ();

    cpu_reg_file_pc #(.DATA_W(DW), .SEL_W(SW), .PC_STEP(4), .PC_RESET(0)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (rf_if)
    );

    // clock / reset block
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic idle();
        CLR           = 1'b0;
        rf_if.TICK    = 1'b1;
        rf_if.REG_WE  = 1'b0;
        rf_if.MARK_EN = 1'b0;
        rf_if.PC_EN   = 1'b0;
        rf_if.PC_INC  = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge CLK);
        idle();
    endtask

    // reference model: state updated from the rules at every rising edge
    always @(posedge CLK) begin
        if (CLR) begin
            for (int i = 0; i < 16; i++) begin
                m_reg[i]  <= '0;
                m_pend[i] <= 1'b0;
            end
            m_pc <= '0;
        end else if (rf_if.TICK) begin
            if (rf_if.REG_WE && rf_if.REG_SEL != 4'd15) begin
                m_reg[rf_if.REG_SEL]  <= rf_if.REG_BUS;
                m_pend[rf_if.REG_SEL] <= 1'b0;
            end
            if (rf_if.MARK_EN && rf_if.MARK_SEL != 4'd15) m_pend[rf_if.MARK_SEL] <= 1'b1;
            if (rf_if.PC_EN)       m_pc <= rf_if.PC_BUS;
            else if (rf_if.PC_INC) m_pc <= m_pc + 32'd4;
        end
    end

    function automatic logic [DW-1:0] exp_rd(input logic [SW-1:0] s);
        if (s == 4'd15) return m_pc;
`ifdef RF_BYPASS_EN
        if (rf_if.TICK && rf_if.REG_WE && rf_if.REG_SEL == s) return rf_if.REG_BUS;
`endif
        return m_reg[s];
    endfunction

    function automatic logic exp_busy(input logic [SW-1:0] s);
        if (s == 4'd15) return 1'b0;
`ifdef RF_BYPASS_EN
        if (rf_if.TICK && rf_if.REG_WE && rf_if.REG_SEL == s)
            return rf_if.MARK_EN && rf_if.MARK_SEL == s;
`endif
        return m_pend[s];
    endfunction

    // scoreboard compare process
    always @(negedge CLK) begin
        #2;
        if (chk_en) begin
            chk("m_rd1",   rf_if.REG_1_OUT, exp_rd(rf_if.REG_1_SEL));
            chk("m_rd2",   rf_if.REG_2_OUT, exp_rd(rf_if.REG_2_SEL));
            chk("m_busy1", 32'(rf_if.REG_1_BUSY), 32'(exp_busy(rf_if.REG_1_SEL)));
            chk("m_busy2", 32'(rf_if.REG_2_BUSY), 32'(exp_busy(rf_if.REG_2_SEL)));
            chk("m_pc",    rf_if.PC_OUT, m_pc);
        end
    end

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        chk_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_pc = '0;
        idle();
        CLR             = 1'b1;
        rf_if.REG_SEL   = '0;
        rf_if.REG_BUS   = '0;
        rf_if.REG_1_SEL = '0;
        rf_if.REG_2_SEL = '0;
        rf_if.MARK_SEL  = '0;
        rf_if.PC_BUS    = '0;
        @(negedge CLK);
        idle();
        chk_en = 1'b1;

        // reset state over all selects
        for (int i = 0; i < 16; i++) begin
            rf_if.REG_1_SEL = 4'(i);
            rf_if.REG_2_SEL = 4'(15 - i);
            #2;
            chk("rst_rd1", rf_if.REG_1_OUT, 32'h0);
            chk("rst_rd2", rf_if.REG_2_OUT, 32'h0);
            chk("rst_busy1", 32'(rf_if.REG_1_BUSY), 32'h0);
            chk("rst_busy2", 32'(rf_if.REG_2_BUSY), 32'h0);
            next_cycle();
        end
        chk("rst_pc", rf_if.PC_OUT, 32'h0);

        // write / read
        rf_if.REG_WE = 1'b1; rf_if.REG_SEL = 4'd3;  rf_if.REG_BUS = 32'hDEADBEEF;
        next_cycle();
        rf_if.REG_WE = 1'b1; rf_if.REG_SEL = 4'd14; rf_if.REG_BUS = 32'h12345678;
        next_cycle();
        rf_if.REG_1_SEL = 4'd3; rf_if.REG_2_SEL = 4'd14;
        #2;
        chk("wr_r3",  rf_if.REG_1_OUT, 32'hDEADBEEF);
        chk("wr_r14", rf_if.REG_2_OUT, 32'h12345678);
        rf_if.REG_WE = 1'b1; rf_if.REG_SEL = 4'd15; rf_if.REG_BUS = 32'h55;
        next_cycle();
        rf_if.REG_1_SEL = 4'd15;
        #2;
        chk("wr_top_pc",  rf_if.PC_OUT, 32'h0);
        chk("wr_top_rd1", rf_if.REG_1_OUT, 32'h0);

        // PC increment, priority, wrap
        exp_q.push_back(32'd4);
        exp_q.push_back(32'd8);
        exp_q.push_back(32'd12);
        repeat (3) begin
            rf_if.PC_INC = 1'b1;
            next_cycle();
            #2;
            chk("pc_inc", rf_if.PC_OUT, exp_q.pop_front());
        end
        rf_if.PC_EN = 1'b1; rf_if.PC_INC = 1'b1; rf_if.PC_BUS = 32'h100;
        next_cycle();
        #2;
        chk("pc_en_prio", rf_if.PC_OUT, 32'h100);
        rf_if.PC_EN = 1'b1; rf_if.PC_BUS = 32'hFFFFFFFC;
        next_cycle();
        #2;
        chk("pc_load", rf_if.PC_OUT, 32'hFFFFFFFC);
        rf_if.PC_INC = 1'b1;
        next_cycle();
        #2;
        chk("pc_wrap", rf_if.PC_OUT, 32'h0);

        // scoreboard
        rf_if.MARK_EN = 1'b1; rf_if.MARK_SEL = 4'd5;
        next_cycle();
        rf_if.REG_1_SEL = 4'd5;
        #2;
        chk("mark_busy", 32'(rf_if.REG_1_BUSY), 32'h1);
        rf_if.REG_WE = 1'b1; rf_if.REG_SEL = 4'd5; rf_if.REG_BUS = 32'h11;
        next_cycle();
        #2;
        chk("wr_clr_busy", 32'(rf_if.REG_1_BUSY), 32'h0);
        chk("wr_clr_data", rf_if.REG_1_OUT, 32'h11);
        rf_if.MARK_EN = 1'b1; rf_if.MARK_SEL = 4'd5;
        rf_if.REG_WE = 1'b1; rf_if.REG_SEL = 4'd5; rf_if.REG_BUS = 32'h77;
        next_cycle();
        #2;
        chk("mark_wins_busy", 32'(rf_if.REG_1_BUSY), 32'h1);
        chk("mark_wins_data", rf_if.REG_1_OUT, 32'h77);

        // TICK gating
        rf_if.TICK = 1'b0;
        rf_if.REG_WE = 1'b1; rf_if.REG_SEL = 4'd3; rf_if.REG_BUS = 32'h0;
        rf_if.PC_INC = 1'b1;
        rf_if.MARK_EN = 1'b1; rf_if.MARK_SEL = 4'd3;
        next_cycle();
        rf_if.REG_1_SEL = 4'd3; rf_if.REG_2_SEL = 4'd5;
        #2;
        chk("tick0_data",  rf_if.REG_1_OUT, 32'hDEADBEEF);
        chk("tick0_mark",  32'(rf_if.REG_1_BUSY), 32'h0);
        chk("tick0_pend",  32'(rf_if.REG_2_BUSY), 32'h1);
        chk("tick0_pc",    rf_if.PC_OUT, 32'h0);
        CLR = 1'b1; rf_if.TICK = 1'b0;
        next_cycle();
        #2;
        chk("clr_tick0_data", rf_if.REG_1_OUT, 32'h0);
        chk("clr_tick0_r5",   rf_if.REG_2_OUT, 32'h0);
        chk("clr_tick0_busy", 32'(rf_if.REG_2_BUSY), 32'h0);

        // same-cycle write visibility
        next_cycle();
        rf_if.REG_WE = 1'b1; rf_if.REG_SEL = 4'd2; rf_if.REG_BUS = 32'hA5A5A5A5;
        rf_if.REG_2_SEL = 4'd2;
        #2;
`ifdef RF_BYPASS_EN
        chk("byp_same", rf_if.REG_2_OUT, 32'hA5A5A5A5);
`else
        chk("byp_same", rf_if.REG_2_OUT, 32'h0);
`endif
        next_cycle();
        #2;
        chk("byp_next", rf_if.REG_2_OUT, 32'hA5A5A5A5);

        // randomized run
        for (int n = 0; n < 3000; n++) begin
            @(negedge CLK);
            CLR             = ($urandom_range(0, 63) == 0);
            rf_if.TICK      = ($urandom_range(0, 3) != 0);
            rf_if.REG_WE    = $urandom_range(0, 1) == 1;
            rf_if.REG_SEL   = 4'($urandom_range(0, 15));
            rf_if.REG_BUS   = $urandom;
            rf_if.MARK_EN   = ($urandom_range(0, 3) == 0);
            rf_if.MARK_SEL  = ($urandom_range(0, 3) == 0) ? rf_if.REG_SEL : 4'($urandom_range(0, 15));
            rf_if.PC_EN     = ($urandom_range(0, 7) == 0);
            rf_if.PC_INC    = $urandom_range(0, 1) == 1;
            rf_if.PC_BUS    = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC : $urandom;
            rf_if.REG_1_SEL = ($urandom_range(0, 2) == 0) ? rf_if.REG_SEL : 4'($urandom_range(0, 15));
            rf_if.REG_2_SEL = ($urandom_range(0, 2) == 0) ? rf_if.REG_SEL : 4'($urandom_range(0, 15));
        end

        // final report
        @(negedge CLK);
        idle();
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cpu_reg_file_pc.md
Name: cpu_reg_file_pc

Overview:
Parametrised successor to the fixed 15-GPR + PC register block for the educational soft CPU. It provides 2^SEL_W entries. Index 2^SEL_W-1 is the program counter; all lower indices are general-purpose registers. It has one write port, two asynchronous read ports, a PC with load and auto-increment, and a per-register pending-write scoreboard. The control unit uses the scoreboard to stall on load-use hazards. The block sits between the decode stage (selects) and the ALU/memory writeback buses.

Parameters:
DATA_W, 32, width of every register and bus.
SEL_W, 4, select width; 2^SEL_W entries; top index is the PC.
PC_STEP, 4, increment added to PC on PC_INC.
PC_RESET, 0, PC value after CLR.

Ports:
CLK  in  1  system clock; all state updates on the rising edge.
CLR  in  1  synchronous active-high reset.
TICK  in  1  clock-tree enable; no state changes when low, CLR excepted.
REG_WE  in  1  GPR write enable.
REG_SEL  in  SEL_W  GPR write index.
REG_BUS  in  DATA_W  GPR write data.
REG_1_SEL  in  SEL_W  read port 1 index.
REG_2_SEL  in  SEL_W  read port 2 index.
REG_1_OUT  out  DATA_W  read port 1 data.
REG_2_OUT  out  DATA_W  read port 2 data.
REG_1_BUSY  out  1  pending bit of the register at REG_1_SEL.
REG_2_BUSY  out  1  pending bit of the register at REG_2_SEL.
MARK_EN  in  1  set pending bit (load issued).
MARK_SEL  in  SEL_W  register to mark pending.
PC_EN  in  1  load PC from PC_BUS.
PC_INC  in  1  PC <= PC + PC_STEP.
PC_BUS  in  DATA_W  PC load value.
PC_OUT  out  DATA_W  current PC.

Behaviour:
- Reset (CLR=1 at an edge, regardless of TICK):
  - all GPRs = 0; PC = PC_RESET; all pending bits = 0.
  - Outputs then read 0, PC_RESET, BUSY=0.
- Reads are combinational, zero latency.
  - REG_n_OUT = entry[REG_n_SEL].
  - Index 2^SEL_W-1 returns the PC.
- GPR write:
  - Condition: edge with TICK=1, REG_WE=1, REG_SEL != 2^SEL_W-1.
  - Effect: entry[REG_SEL] <= REG_BUS, visible the cycle after the edge.
  - A write with REG_SEL = 2^SEL_W-1 is ignored; the PC is written only through the PC port.
- PC, on an edge with TICK=1:
  - PC_EN=1: PC <= PC_BUS. PC_EN has priority over PC_INC.
  - PC_EN=0, PC_INC=1: PC <= PC + PC_STEP, modulo 2^DATA_W (wraps, no flag).
  - Otherwise PC holds.
- Scoreboard: one pending bit per GPR; none for the PC. On an edge with TICK=1:
  - A GPR write to index i clears pend[i].
  - MARK_EN=1 sets pend[MARK_SEL].
  - MARK_SEL = top index is ignored.
  - If a mark and a write hit the same index in the same cycle, the mark wins: pend=1, data is still written.
- REG_n_BUSY = pend[REG_n_SEL]; always 0 for the top index. Combinational.
- TICK=0: all registers, the PC and pending bits hold, even if REG_WE, PC_EN, PC_INC or MARK_EN are asserted.
- CLR has priority over every other input. A CLR asserted mid-operation discards any simultaneous write, mark or PC update.
- Implementation note: the write decoder is a 2^SEL_W one-hot vector. Read muxes are generic, built over a flattened array.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: write-through forwarding.
  - Condition: TICK=1, REG_WE=1, REG_SEL == REG_n_SEL, and the index is not the top index.
  - REG_n_OUT = REG_BUS in the same cycle.
  - REG_n_BUSY = 0 unless MARK_EN targets the same index that cycle.
- Undefined: read ports show stored values only; the written data appears the cycle after the edge.

Test Plan:
- Reset: CLR=1 for 1 cycle, PC_RESET=0 -> REG_1_OUT=REG_2_OUT=0 for all selects; PC_OUT=0; BUSY=0.
- Write/read: TICK=1, write 0xDEADBEEF to R3, then 0x12345678 to R14; read sel 3 and 14 -> next cycle outputs 0xDEADBEEF and 0x12345678. A write to index 15 leaves PC_OUT unchanged.
- PC:
  - PC_INC for 3 cycles from 0 -> 4, 8, 12.
  - PC_EN=1 and PC_INC=1 with PC_BUS=0x100 -> 0x100.
  - PC_BUS=0xFFFFFFFC then PC_INC -> 0x00000000.
- Scoreboard:
  - MARK_EN on R5 -> REG_1_BUSY=1 with REG_1_SEL=5.
  - Write R5 -> BUSY=0 next cycle.
  - Mark and write R5 in the same cycle -> BUSY stays 1; data is updated.
- TICK gating: TICK=0 with REG_WE, PC_INC, MARK_EN all high -> no change. CLR=1 with TICK=0 -> reset still occurs.
- Bypass (RF_BYPASS_EN defined): write 0xA5A5A5A5 to R2 while REG_2_SEL=2 -> REG_2_OUT=0xA5A5A5A5 in the same cycle. Without the macro -> old value that cycle, new value the next.
